ctrl_fsm: RTL and testbench

Parametrised multi-cycle instruction control unit for the teaching CPU, sitting between the fetch/PC logic, register file and ALU. It sequences INIT → IF → ID → EX → WB, decodes a full ALU opcode class plus load-immediate, jump, branch-if-zero and halt, and emits one-cycle strobes for fetch, operand grouping and PC update. It generalises register count, opcode width and ALU function width, and adds a control-flow path and a halt state.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/pulse_gen.sv | 25 ++
 rtl/ctrl_fsm.sv | 153 +++++++++++++++
 tb/tb_ctrl_fsm.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ctrl_fsm instruction sequencer.
// The EX_BR state exists only when CTRL_BRANCH_EN is defined.
package ctrl_pkg;

   typedef enum logic [2:0] {
      StInit,
      StIf,
      StId,
      StExAl,
`ifdef CTRL_BRANCH_EN
      StExBr,
`endif
      StWb,
      StHalt
   } state_e;

   // Control-class sub-opcodes: low opcode bits when the opcode MSB is set.
   localparam logic [2:0] OPC_JMP  = 3'b000;
   localparam logic [2:0] OPC_BEQZ = 3'b001;
   localparam logic [2:0] OPC_LDI  = 3'b010;
   localparam logic [2:0] OPC_HALT = 3'b111;

   localparam logic [1:0] PC_HOLD = 2'b00;
   localparam logic [1:0] PC_INC  = 2'b01;
   localparam logic [1:0] PC_LOAD = 2'b10;

   localparam int unsigned ALU_ADD   = 0;
   localparam int unsigned ALU_PASSB = 7;

endpackage

// File: rtl/pulse_gen.sv
// One-cycle strobe from a decoded enable level: fires on state entry,
// stays quiet while the state holds with the level already high.
module pulse_gen (
   input  logic clk,
   input  logic rst_n,
   input  logic level_i,
   input  logic hold_i,
   output logic pulse_o
);

   logic level_d, level_q;

   assign level_d = level_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level_d;
      end
   end

   assign pulse_o = level_i & ~(level_q & hold_i);

endmodule

// File: rtl/ctrl_fsm.sv
// Multi-cycle control unit: INIT -> IF -> ID -> EX -> WB, plus HALT.
// Define CTRL_BRANCH_EN to enable the JMP/BEQZ path through EX_BR.
module ctrl_fsm #(
   parameter int unsigned OPC_W      = 4,
   parameter int unsigned REG_NUM    = 4,
   parameter int unsigned RD_W       = $clog2(REG_NUM),
   parameter int unsigned ALU_FUNC_W = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en_in,
   input  logic                  fetch_done,
   input  logic                  alu_done,
   input  logic                  zero,
   input  logic [OPC_W-1:0]      opcode,
   input  logic [RD_W-1:0]       rd,
   output logic                  en_fetch_pulse,
   output logic                  en_group_pulse,
   output logic                  en_pc_pulse,
   output logic [1:0]            pc_ctrl,
   output logic [REG_NUM-1:0]    reg_en,
   output logic                  alu_in_sel,
   output logic [ALU_FUNC_W-1:0] alu_func,
   output logic                  halted
);
   import ctrl_pkg::*;

   state_e state_d, state_q;

   logic [OPC_W-2:0] sub_opc;
   logic is_alu, is_ldi, is_halt;
   logic fetch_lvl, group_lvl, pc_lvl, hold;

   assign sub_opc = opcode[OPC_W-2:0];
   assign is_alu  = ~opcode[OPC_W-1];
   assign is_ldi  = opcode[OPC_W-1] & (sub_opc == (OPC_W-1)'(OPC_LDI));
   assign is_halt = opcode[OPC_W-1] & (sub_opc == (OPC_W-1)'(OPC_HALT));

`ifdef CTRL_BRANCH_EN
   logic is_jmp, is_beqz, br_taken;
   assign is_jmp   = opcode[OPC_W-1] & (sub_opc == (OPC_W-1)'(OPC_JMP));
   assign is_beqz  = opcode[OPC_W-1] & (sub_opc == (OPC_W-1)'(OPC_BEQZ));
   // EX_BR is only ever next_state from ID, so zero here is the ID-cycle sample.
   assign br_taken = is_jmp | (is_beqz & zero);
`else
   logic unused_zero;
   assign unused_zero = zero;
`endif

   always_comb begin
      state_d = state_q;
      case (state_q)
         StInit: if (en_in) state_d = StIf;
         StIf:   if (fetch_done) state_d = StId;
         StId: begin
            if (is_alu || is_ldi) begin
               state_d = StExAl;
            end else if (is_halt) begin
               state_d = StHalt;
`ifdef CTRL_BRANCH_EN
            end else if (is_jmp || is_beqz) begin
               state_d = StExBr;
`endif
            end else begin
               state_d = StIf;
            end
         end
         StExAl: if (alu_done) state_d = StWb;
`ifdef CTRL_BRANCH_EN
         StExBr: state_d = StIf;
`endif
         StWb:   state_d = StIf;
         StHalt: state_d = StHalt;
         default: state_d = StInit;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StInit;
      end else begin
         state_q <= state_d;
      end
   end

   // Outputs describe the state being entered; held at reset values while rst_n is low.
   always_comb begin
      fetch_lvl  = 1'b0;
      group_lvl  = 1'b0;
      pc_lvl     = 1'b0;
      pc_ctrl    = PC_HOLD;
      reg_en     = '0;
      alu_in_sel = 1'b0;
      alu_func   = ALU_FUNC_W'(ALU_ADD);
      if (rst_n) begin
         case (state_d)
            StIf: begin
               fetch_lvl = 1'b1;
               pc_lvl    = 1'b1;
               pc_ctrl   = PC_INC;
            end
            StExAl: begin
               group_lvl = 1'b1;
               if (is_ldi) begin
                  alu_in_sel = 1'b0;
                  alu_func   = ALU_FUNC_W'(ALU_PASSB);
               end else begin
                  alu_in_sel = 1'b1;
                  alu_func   = opcode[ALU_FUNC_W-1:0];
               end
            end
`ifdef CTRL_BRANCH_EN
            StExBr: begin
               if (br_taken) begin
                  pc_lvl  = 1'b1;
                  pc_ctrl = PC_LOAD;
               end
            end
`endif
            StWb: reg_en = REG_NUM'(1) << rd;
            default: ;
         endcase
      end
   end

   assign hold   = (state_d == state_q);
   assign halted = rst_n & (state_q == StHalt);

   pulse_gen u_fetch_pulse (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_i (fetch_lvl),
      .hold_i  (hold),
      .pulse_o (en_fetch_pulse)
   );

   pulse_gen u_group_pulse (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_i (group_lvl),
      .hold_i  (hold),
      .pulse_o (en_group_pulse)
   );

   pulse_gen u_pc_pulse (
      .clk     (clk),
      .rst_n   (rst_n),
      .level_i (pc_lvl),
      .hold_i  (hold),
      .pulse_o (en_pc_pulse)
   );

endmodule

// File: tb/tb_ctrl_fsm.sv
// Bench for ctrl_fsm: phase model checked every cycle plus directed literal checks.
// Honours CTRL_BRANCH_EN in the same way as the design.
module tb_ctrl_fsm;

   logic       clk = 1'b0;
   logic       rst_n, en_in, fetch_done, alu_done, zero;
   logic [3:0] opcode;
   logic [1:0] rd;
   logic       en_fetch_pulse, en_group_pulse, en_pc_pulse;
   logic [1:0] pc_ctrl;
   logic [3:0] reg_en;
   logic       alu_in_sel;
   logic [2:0] alu_func;
   logic       halted;

   int passes = 0;
   int total  = 0;

   always #5 clk = ~clk;

   ctrl_fsm dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en_in          (en_in),
      .fetch_done     (fetch_done),
      .alu_done       (alu_done),
      .zero           (zero),
      .opcode         (opcode),
      .rd             (rd),
      .en_fetch_pulse (en_fetch_pulse),
      .en_group_pulse (en_group_pulse),
      .en_pc_pulse    (en_pc_pulse),
      .pc_ctrl        (pc_ctrl),
      .reg_en         (reg_en),
      .alu_in_sel     (alu_in_sel),
      .alu_func       (alu_func),
      .halted         (halted)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
   endtask

   // {fetch, group, pc, pc_ctrl[1:0], reg_en[3:0], alu_in_sel, alu_func[2:0], halted}
   function automatic logic [31:0] outs();
      return 32'({en_fetch_pulse, en_group_pulse, en_pc_pulse, pc_ctrl, reg_en,
                  alu_in_sel, alu_func, halted});
   endfunction

   // ---------------- phase model ----------------
   typedef enum int {PInit, PFetch, PDecode, PExec, PBranch, PWrite, PHalt} phase_t;

   phase_t m_phase = PInit;
   phase_t m_next  = PInit;
   logic   m_f_lvl = 1'b0, m_g_lvl = 1'b0, m_p_lvl = 1'b0;
   logic   m_f_prev = 1'b0, m_g_prev = 1'b0, m_p_prev = 1'b0;

   function automatic phase_t decode_dest(input logic [3:0] opc);
      if (!opc[3] || opc == 4'b1010) return PExec;
      if (opc == 4'b1111) return PHalt;
`ifdef CTRL_BRANCH_EN
      if (opc == 4'b1000 || opc == 4'b1001) return PBranch;
`endif
      return PFetch;
   endfunction

   always @(negedge clk) begin : model_cmp
      phase_t     nxt;
      logic       f, g, p, ais, h, ef, eg, ep;
      logic [1:0] pcc;
      logic [3:0] re;
      logic [2:0] af;
      f = 1'b0; g = 1'b0; p = 1'b0; ais = 1'b0; h = 1'b0;
      pcc = 2'b00; re = 4'b0000; af = 3'd0;
      nxt = PInit;
      if (rst_n) begin
         nxt = m_phase;
         case (m_phase)
            PInit:   if (en_in) nxt = PFetch;
            PFetch:  if (fetch_done) nxt = PDecode;
            PDecode: nxt = decode_dest(opcode);
            PExec:   if (alu_done) nxt = PWrite;
            PBranch: nxt = PFetch;
            PWrite:  nxt = PFetch;
            default: nxt = PHalt;
         endcase
         h = (m_phase == PHalt);
         case (nxt)
            PFetch: begin f = 1'b1; p = 1'b1; pcc = 2'b01; end
            PExec: begin
               g = 1'b1;
               if (opcode == 4'b1010) begin ais = 1'b0; af = 3'd7; end
               else begin ais = 1'b1; af = opcode[2:0]; end
            end
            PBranch: if (opcode == 4'b1000 || zero) begin p = 1'b1; pcc = 2'b10; end
            PWrite: re = 4'b0001 << rd;
            default: ;
         endcase
      end
      // A strobe fires whenever its level is high, except when a held phase already had it high.
      ef = f && !(m_f_prev && nxt == m_phase);
      eg = g && !(m_g_prev && nxt == m_phase);
      ep = p && !(m_p_prev && nxt == m_phase);
      check("model", outs(), 32'({ef, eg, ep, pcc, re, ais, af, h}));
      m_next  <= nxt;
      m_f_lvl <= f;
      m_g_lvl <= g;
      m_p_lvl <= p;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase  <= PInit;
         m_f_prev <= 1'b0;
         m_g_prev <= 1'b0;
         m_p_prev <= 1'b0;
      end else begin
         m_phase  <= m_next;
         m_f_prev <= m_f_lvl;
         m_g_prev <= m_g_lvl;
         m_p_prev <= m_p_lvl;
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int nf, ng, np, nr;
      rst_n = 1'b0; en_in = 1'b0; fetch_done = 1'b0; alu_done = 1'b0;
      zero = 1'b0; opcode = 4'b0000; rd = 2'd0;
      next_cycle();
      // Inputs that would start an instruction must have no effect while in reset.
      en_in = 1'b1; fetch_done = 1'b1; alu_done = 1'b1; rd = 2'd2;
      @(negedge clk);
      check("reset_outputs", outs(), 32'h0);
      check("reset_alu_func", 32'(alu_func), 32'd0);
      next_cycle();
      rst_n = 1'b1;

      // ADD, rd=2, everything ready: one instruction spans 4 cycles.
      nf = 0; ng = 0; np = 0; nr = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         nf += int'(en_fetch_pulse);
         ng += int'(en_group_pulse);
         np += int'(en_pc_pulse);
         if (reg_en == 4'b0100) nr++;
         next_cycle();
      end
      check("add_fetch_count", 32'(nf), 32'd1);
      check("add_group_count", 32'(ng), 32'd1);
      check("add_pc_count", 32'(np), 32'd1);
      check("add_regen_cycles", 32'(nr), 32'd1);

      // WB -> IF: next fetch strobe lands 4 cycles after the first one.
      fetch_done = 1'b0;
      @(negedge clk);
      check("add_period4_fetch", 32'(en_fetch_pulse), 32'd1);
      next_cycle();

      // IF stalled 5 cycles: strobes must not repeat.
      opcode = 4'b1010; rd = 2'd3;
      nf = 0; np = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nf += int'(en_fetch_pulse);
         np += int'(en_pc_pulse);
         next_cycle();
      end
      check("stall_fetch_repeat", 32'(nf), 32'd0);
      check("stall_pc_repeat", 32'(np), 32'd0);

      // LDI rd=3.
      fetch_done = 1'b1;
      next_cycle();
      @(negedge clk);
      check("ldi_alu_in_sel", 32'(alu_in_sel), 32'd0);
      check("ldi_alu_func", 32'(alu_func), 32'd7);
      check("ldi_group_pulse", 32'(en_group_pulse), 32'd1);
      next_cycle();
      @(negedge clk);
      check("ldi_reg_en", 32'(reg_en), 32'b1000);
      next_cycle();
      next_cycle();

      // Now in IF: BEQZ.
      opcode = 4'b1001; zero = 1'b1;
      next_cycle();
`ifdef CTRL_BRANCH_EN
      @(negedge clk);
      check("beqz_taken_pc_ctrl", 32'(pc_ctrl), 32'b10);
      check("beqz_taken_pc_pulse", 32'(en_pc_pulse), 32'd1);
      next_cycle();
      @(negedge clk);
      check("beqz_refetch_pc_ctrl", 32'(pc_ctrl), 32'b01);
      check("beqz_refetch_pc_pulse", 32'(en_pc_pulse), 32'd1);
      next_cycle();
      zero = 1'b0;
      next_cycle();
      @(negedge clk);
      check("beqz_not_taken_pc_pulse", 32'(en_pc_pulse), 32'd0);
      check("beqz_not_taken_pc_ctrl", 32'(pc_ctrl), 32'b00);
      next_cycle();
      next_cycle();
`else
      @(negedge clk);
      check("beqz_as_nop_pc_ctrl", 32'(pc_ctrl), 32'b01);
      check("beqz_as_nop_fetch_pulse", 32'(en_fetch_pulse), 32'd1);
      next_cycle();
`endif

      // Now in IF: HALT, then 20 cycles with en_in high.
      opcode = 4'b1111;
      next_cycle();
      next_cycle();
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("halt_outputs", outs(), 32'h1);
         next_cycle();
      end

      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1; en_in = 1'b0;
      @(negedge clk);
      check("recover_idle", outs(), 32'h0);
      next_cycle();
      en_in = 1'b1; opcode = 4'b0000; rd = 2'd1; alu_done = 1'b0;
      @(negedge clk);
      check("recover_start_fetch", 32'(en_fetch_pulse), 32'd1);
      next_cycle();
      next_cycle();
      next_cycle();
      // Holding in EX_AL; reset must clear outputs without waiting for a clock.
      rst_n = 1'b0;
      #1;
      check("reset_in_exal", outs(), 32'h0);
      next_cycle();
      rst_n = 1'b1; en_in = 1'b0; alu_done = 1'b1;
      nr = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (reg_en != 4'b0000) nr++;
         next_cycle();
      end
      check("no_partial_wb", 32'(nr), 32'd0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
